// File: rtl/game_flow_controller.sv
// Game-flow FSM for the pinball screen: welcome, play, timed pause after a lost
// ball, and an end screen with a key hold-off and an automatic return to welcome.
module game_flow_controller #(
  parameter int LOSS_PAUSE_FRAMES  = 60,
  parameter int END_HOLD_FRAMES    = 120,
  parameter int END_TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       key0IsPressed,
  input  logic [3:0] life,
  output logic       start,
  output logic       game_end,
  output logic       paused,
  output logic       new_game,
  output logic [7:0] games_played
);

  typedef enum logic [1:0] {
    WELCOME    = 2'd0,
    PLAY       = 2'd1,
    LOSS_PAUSE = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic [9:0] PAUSE_LAST   = 10'(LOSS_PAUSE_FRAMES - 1);
  localparam logic [9:0] HOLD_FRAMES  = 10'(END_HOLD_FRAMES);
  localparam logic [9:0] TIMEOUT_LAST = 10'(END_TIMEOUT_FRAMES - 1);

  state_t     state;
  state_t     state_next;
  logic       key_q;
  logic       key_evt;
  logic [9:0] frame_cnt;
  logic       settle;
  logic [3:0] life_prev;

  assign key_evt = key0IsPressed & ~key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WELCOME;
    else       state <= state_next;
  end

  // The settle frame only refreshes life_prev, giving screen_main time to reload life.
  always_comb begin
    state_next = state;
    case (state)
      WELCOME: if (key_evt) state_next = PLAY;
      PLAY: begin
        if (startOfFrame && !settle) begin
          if (life == 4'd0)          state_next = GAME_OVER;
          else if (life < life_prev) state_next = LOSS_PAUSE;
        end
      end
      LOSS_PAUSE: if (startOfFrame && frame_cnt == PAUSE_LAST) state_next = PLAY;
      GAME_OVER: begin
        if ((key_evt && frame_cnt >= HOLD_FRAMES) ||
            (startOfFrame && frame_cnt == TIMEOUT_LAST))
          state_next = WELCOME;
      end
      default: state_next = WELCOME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q        <= 1'b0;
      frame_cnt    <= 10'd0;
      settle       <= 1'b0;
      life_prev    <= 4'd0;
      games_played <= 8'd0;
      new_game     <= 1'b0;
    end else begin
      key_q    <= key0IsPressed;
      new_game <= (state == WELCOME) && key_evt;
      if (state_next != state)
        frame_cnt <= 10'd0;
      else if (startOfFrame && (state == LOSS_PAUSE || state == GAME_OVER))
        frame_cnt <= frame_cnt + 10'd1;
      if (state == WELCOME && key_evt)
        settle <= 1'b1;
      else if (state == PLAY && startOfFrame)
        settle <= 1'b0;
      if (state == PLAY && startOfFrame)
        life_prev <= life;
      if (state == PLAY && state_next == GAME_OVER && games_played != 8'd255)
        games_played <= games_played + 8'd1;
    end
  end

  always_comb begin
    start    = (state == PLAY) || (state == LOSS_PAUSE);
    game_end = (state == GAME_OVER);
    paused   = (state == LOSS_PAUSE);
  end

endmodule
